// File: rtl/adder_arbiter.sv
// Round-robin arbiter granting three requesters access to one shared external adder.
// Each operation takes one IDLE cycle to grant and one EXEC cycle to capture the sum.
module adder_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [2:0]       REQ,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B2,
  output logic [WIDTH-1:0] ADD_A,
  output logic [WIDTH-1:0] ADD_B,
  input  logic [WIDTH-1:0] ADD_R,
  output logic [2:0]       GNT,
  output logic [WIDTH-1:0] R,
  output logic [2:0]       DONE,
  output logic             BUSY
);

  typedef enum logic {IDLE, EXEC} state_t;

  state_t           state;
  logic [1:0]       ptr;      // index of the highest-priority requester
  logic [2:0]       elig;
  logic [2:0]       win;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;

  // A requester whose DONE is pulsing still has a stale REQ up; keep it out.
  assign elig = REQ & ~DONE;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    win = 3'b000;
    unique case (ptr)
      2'd0: begin
        if      (elig[0]) win = 3'b001;
        else if (elig[1]) win = 3'b010;
        else if (elig[2]) win = 3'b100;
      end
      2'd1: begin
        if      (elig[1]) win = 3'b010;
        else if (elig[2]) win = 3'b100;
        else if (elig[0]) win = 3'b001;
      end
      default: begin
        if      (elig[2]) win = 3'b100;
        else if (elig[0]) win = 3'b001;
        else if (elig[1]) win = 3'b010;
      end
    endcase
  end

  always_comb begin
    win_a = '0;
    win_b = '0;
    if (win[0]) begin
      win_a = A0;
      win_b = B0;
    end else if (win[1]) begin
      win_a = A1;
      win_b = B1;
    end else if (win[2]) begin
      win_a = A2;
      win_b = B2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr   <= 2'd0;
      GNT   <= 3'b000;
      DONE  <= 3'b000;
      BUSY  <= 1'b0;
      R     <= '0;
      ADD_A <= '0;
      ADD_B <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          DONE <= 3'b000;
          if (|win) begin
            ADD_A <= win_a;
            ADD_B <= win_b;
            GNT   <= win;
            BUSY  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          R     <= ADD_R;
          DONE  <= GNT;
          GNT   <= 3'b000;
          BUSY  <= 1'b0;
          state <= IDLE;
          unique case (GNT)
            3'b001:  ptr <= 2'd1;
            3'b010:  ptr <= 2'd2;
            default: ptr <= 2'd0;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: table-driven grants plus fairness, masking, reset-abort and
// operand-isolation sequences; a negedge monitor pops a scoreboard on every DONE pulse.
module tb_adder_arbiter;

  localparam int WIDTH = 16;

  typedef struct {
    logic [2:0]       req;
    logic [WIDTH-1:0] a0, b0, a1, b1, a2, b2;
    logic [2:0]       exp_gnt;
    logic [WIDTH-1:0] exp_r;
  } vec_t;

  typedef struct packed {
    logic [2:0]       done;
    logic [WIDTH-1:0] r;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       req = 3'b000;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, a2 = '0, b2 = '0;
  logic [WIDTH-1:0] add_a, add_b, add_r, r;
  logic [2:0]       gnt, done;
  logic             busy;

  int   total = 0;
  int   bad = 0;
  bit   started = 0;
  bit   rst_hit = 0;
  logic [WIDTH-1:0] prev_r = '0;
  exp_t sb[$];
  vec_t vecs[7];

  adder_arbiter #(.WIDTH(WIDTH)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ(req),
    .A0(a0), .B0(b0), .A1(a1), .B1(b1), .A2(a2), .B2(b2),
    .ADD_A(add_a), .ADD_B(add_b), .ADD_R(add_r),
    .GNT(gnt), .R(r), .DONE(done), .BUSY(busy)
  );

  // Shared external adder; carry is dropped by the result width.
  assign add_r = add_a + add_b;

  always #5 clk = ~clk;

  always @(posedge clk) rst_hit <= !rst_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 3'b000 && n < 10);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("done_onehot0", 32'($onehot0(done)), 32'd1);
      check("gnt_done_disjoint", 32'(gnt & done), 32'd0);
      check("busy_is_exec", 32'(busy), 32'(|gnt));
      if (done != 3'b000) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_id", 32'(done), 32'(e.done));
          check("result", 32'(r), 32'(e.r));
        end
      end else if (!rst_hit) begin
        check("r_hold", 32'(r), 32'(prev_r));
      end
      prev_r = r;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int   n;
    int   grants;
    int   last_cyc;
    int   gcount;
    bit   drop_next;
    logic [2:0] reraise;
    logic [2:0] exp_g;

    vecs[0] = '{3'b001, 16'h1234, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b001, 16'h1235};
    vecs[1] = '{3'b010, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 16'h0000, 16'h0000, 3'b010, 16'h0001};
    vecs[2] = '{3'b111, 16'h0010, 16'h0001, 16'h0020, 16'h0002, 16'h0030, 16'h0003, 3'b100, 16'h0033};
    vecs[3] = '{3'b111, 16'h0010, 16'h0001, 16'h0020, 16'h0002, 16'h0030, 16'h0003, 3'b001, 16'h0011};
    vecs[4] = '{3'b101, 16'h0010, 16'h0001, 16'h0020, 16'h0002, 16'h0030, 16'h0003, 3'b100, 16'h0033};
    vecs[5] = '{3'b110, 16'h0010, 16'h0001, 16'h0020, 16'h0002, 16'h0030, 16'h0003, 3'b010, 16'h0022};
    vecs[6] = '{3'b011, 16'h8000, 16'h8000, 16'h0020, 16'h0002, 16'h0030, 16'h0003, 3'b001, 16'h0000};

    // Reset with requests pending: REQ must be ignored while reset is low.
    req = 3'b111;
    do_reset();
    req = 3'b000;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    prev_r  = r;
    started = 1;

    for (int i = 0; i < 7; i++) begin
      req = vecs[i].req;
      a0 = vecs[i].a0; b0 = vecs[i].b0;
      a1 = vecs[i].a1; b1 = vecs[i].b1;
      a2 = vecs[i].a2; b2 = vecs[i].b2;
      sb.push_back('{vecs[i].exp_gnt, vecs[i].exp_r});
      wait_gnt(n);
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_latency", i), 32'(n), 32'd1);
      @(negedge clk);
      check($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].exp_gnt));
      req = 3'b000;
      @(negedge clk);
    end

    // Fairness: all three keep requesting; each drops after DONE, re-raises a cycle later.
    do_reset();
    a0 = 16'h0100; b0 = 16'h0001;
    a1 = 16'h0200; b1 = 16'h0002;
    a2 = 16'h0300; b2 = 16'h0003;
    for (int i = 0; i < 6; i++) begin
      exp_g = 3'b001 << (i % 3);
      sb.push_back('{exp_g, (i % 3 == 0) ? 16'h0101 : (i % 3 == 1) ? 16'h0202 : 16'h0303});
    end
    req = 3'b111;
    reraise = 3'b000;
    grants = 0;
    last_cyc = 0;
    for (int cyc = 1; cyc <= 40 && grants < 6; cyc++) begin
      @(negedge clk);
      if (gnt != 3'b000) begin
        exp_g = 3'b001 << (grants % 3);
        check($sformatf("rr_order%0d", grants), 32'(gnt), 32'(exp_g));
        if (grants > 0) check($sformatf("rr_gap%0d", grants), 32'(cyc - last_cyc), 32'd2);
        last_cyc = cyc;
        grants++;
      end
      req = (req & ~done) | reraise;
      reraise = done;
    end
    check("rr_grants", 32'(grants), 32'd6);
    req = 3'b000;
    repeat (2) @(negedge clk);

    // Stale REQ[0] held through the DONE cycle must not be re-granted.
    req = 3'b001; a0 = 16'h0005; b0 = 16'h0007;
    sb.push_back('{3'b001, 16'h000C});
    gcount = 0;
    drop_next = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge clk);
      if (gnt != 3'b000) gcount++;
      if (drop_next) req = 3'b000;
      if (done[0]) drop_next = 1;
    end
    check("stale_grants", 32'(gcount), 32'd1);

    // Reset during EXEC aborts the operation; the request is re-arbitrated afterwards.
    req = 3'b100; a2 = 16'h00AA; b2 = 16'h0011;
    wait_gnt(n);
    check("abort_gnt", 32'(gnt), 32'b100);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_gnt_clr", 32'(gnt), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    sb.push_back('{3'b100, 16'h00BB});
    @(negedge clk);
    check("abort_regrant", 32'(gnt), 32'b100);
    @(negedge clk);
    req = 3'b000;
    @(negedge clk);

    // Operand changes during EXEC must not leak into the result.
    req = 3'b100; a2 = 16'h1111; b2 = 16'h2222;
    sb.push_back('{3'b100, 16'h3333});
    wait_gnt(n);
    check("iso_gnt", 32'(gnt), 32'b100);
    check("iso_add_a", 32'(add_a), 32'h1111);
    check("iso_add_b", 32'(add_b), 32'h2222);
    a2 = 16'hFFFF; b2 = 16'hFFFF;
    @(negedge clk);
    check("iso_r", 32'(r), 32'h3333);
    req = 3'b000;
    repeat (2) @(negedge clk);

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width; it SHALL match the shared 16-bit adder.
REQ-002 Port: CLK  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: RST_N  input  1  reset, synchronous and active-low.
REQ-004 Port: REQ  input  3  per-requester add request, bit i = requester i.
REQ-005 Port: A0, B0  input  WIDTH each  requester 0 operands.
REQ-006 Port: A1, B1  input  WIDTH each  requester 1 operands.
REQ-007 Port: A2, B2  input  WIDTH each  requester 2 operands.
REQ-008 Port: ADD_A, ADD_B  output  WIDTH each  registered operands driven to the shared adder.
REQ-009 Port: ADD_R  input  WIDTH  combinational sum returned from the shared adder.
REQ-010 Port: GNT  output  3  one-hot grant, high for the cycle the granted operation is in the adder.
REQ-011 Port: R  output  WIDTH  registered result of the last completed operation.
REQ-012 Port: DONE  output  3  one-hot, single-cycle pulse marking R valid for requester i.
REQ-013 Port: BUSY  output  1  high when the FSM is not in IDLE.

Function
REQ-014 FSM SHALL have exactly two states: IDLE and EXEC.
REQ-015 IDLE: if any eligible REQ bit is set, the block SHALL select one winner, register its operands into ADD_A/ADD_B, set GNT to the winner's one-hot code, and go to EXEC; otherwise stay in IDLE with GNT = 0.
REQ-016 EXEC: the block SHALL register ADD_R into R, set DONE = GNT for the next cycle, clear GNT, advance the round-robin pointer, and return to IDLE unconditionally.
REQ-017 Latency: REQ sampled in IDLE at edge k -> GNT high in cycle k+1 -> DONE high and R valid in cycle k+2.
REQ-018 Throughput: at most one operation per 2 cycles; a new grant MAY be issued in the same cycle DONE pulses.
REQ-019 Arbitration SHALL be round-robin: priority starts at the requester after the last one granted, wrapping 2 -> 0.
REQ-020 Eligibility: in the cycle DONE[i] is high, REQ[i] SHALL be ignored, so a completing requester is never immediately re-granted on stale REQ.
REQ-021 Requester contract: REQ and operands are held stable from assertion until GNT; REQ is dropped after DONE; REQ dropped before grant withdraws the request without side effects.
REQ-022 Operands SHALL be captured only on the IDLE->EXEC edge; operand changes while in EXEC SHALL NOT affect the result.
REQ-023 Arithmetic: R = (ADD_A + ADD_B) mod 2^WIDTH; the carry SHALL be discarded and no overflow flag produced.
REQ-024 R SHALL hold its value until the next EXEC capture; DONE SHALL be 0 in every cycle except the one following EXEC.
REQ-025 GNT and DONE SHALL each be zero or one-hot at all times; GNT and DONE SHALL never be set for the same requester in the same cycle.
REQ-026 BUSY SHALL equal 1 exactly in EXEC.

Reset
REQ-027 When RST_N = 0 at a rising edge: state <- IDLE, GNT <- 0, DONE <- 0, BUSY <- 0, R <- 0, ADD_A <- 0, ADD_B <- 0, pointer <- requester 0 highest priority.
REQ-028 Reset asserted in EXEC SHALL abort the operation: no DONE pulse, R remains 0, and the aborted requester SHALL be re-arbitrated normally once reset is released if its REQ is still high.
REQ-029 Reset SHALL override all other inputs; REQ is ignored while RST_N = 0.

Verification
REQ-030 Single request: after reset, REQ=001, A0=0x1234, B0=0x0001 -> GNT=001 at k+1, DONE=001 and R=0x1235 at k+2, BUSY high only at k+1.
REQ-031 Wrap-around: REQ=010, A1=0xFFFF, B1=0x0002 -> DONE=010, R=0x0001, no other output change.
REQ-032 Round-robin fairness: REQ=111 held, each requester drops REQ after its DONE and re-raises it one cycle later -> grant order 0,1,2,0,1,2 with GNT pulses every 2 cycles.
REQ-033 Stale-request masking: only REQ[0] high, held one cycle past DONE -> exactly one grant and one DONE for requester 0; no second GNT.
REQ-034 Reset mid-operation: RST_N=0 for one edge while in EXEC with REQ=100 -> next cycle GNT=0, DONE=0, R=0; after release, with REQ=100 still high -> GNT=100 next cycle.
REQ-035 Operand isolation: change A2/B2 during EXEC after the grant -> R equals the sum of the values present at grant.
